// File: rtl/regfile_dump_tx.sv
// regfile_dump_tx: walks register numbers FIRST_REG..LAST_REG through one
// register-file read port and streams each 32-bit word big-endian as bytes
// on a valid/ready byte interface. Read-only with respect to the register file.
// Optional feature macro: REG_DUMP_INDEX_EN -- prefix each word with an index
// byte {3'b000, rn}, giving five bytes per register instead of four.
module regfile_dump_tx #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  output logic [4:0]  rn,
  input  logic [31:0] q,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

`ifdef REG_DUMP_INDEX_EN
  localparam int unsigned NBYTES = 5;
`else
  localparam int unsigned NBYTES = 4;
`endif
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t           state, state_n;
  logic [4:0]       rn_n;
  logic [31:0]      shift, shift_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       tx_data_n;

  // Next-state, next read address, shift/counter and next offered byte
  always_comb begin
    state_n   = state;
    rn_n      = rn;
    shift_n   = shift;
    cnt_n     = cnt;
    tx_data_n = tx_data;
    unique case (state)
      IDLE: begin
        rn_n = 5'(FIRST_REG);
        if (start) state_n = LOAD;
      end
      LOAD: begin
        shift_n = q;
        cnt_n   = '0;
        state_n = SEND;
`ifdef REG_DUMP_INDEX_EN
        tx_data_n = {3'b000, rn};
`else
        tx_data_n = q[31:24];
`endif
      end
      SEND: begin
        if (tx_ready) begin
          cnt_n = cnt + CNT_W'(1);
`ifdef REG_DUMP_INDEX_EN
          // index byte just went out: offer the MSB without shifting
          if (cnt == '0) begin
            tx_data_n = shift[31:24];
          end else begin
            shift_n   = shift << 8;
            tx_data_n = shift[23:16];
          end
`else
          shift_n   = shift << 8;
          tx_data_n = shift[23:16];
`endif
          // last byte of the word: finish, or step to the next register
          if (cnt == CNT_W'(NBYTES - 1)) begin
            if (rn == 5'(LAST_REG)) begin
              state_n = DONE;
            end else begin
              rn_n    = rn + 5'd1;
              state_n = LOAD;
            end
          end
        end
      end
      DONE: begin
        rn_n    = 5'(FIRST_REG);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any partially sent word
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      rn       <= 5'(FIRST_REG);
      shift    <= '0;
      cnt      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      rn       <= rn_n;
      shift    <= shift_n;
      cnt      <= cnt_n;
      tx_data  <= tx_data_n;
      tx_valid <= (state_n == SEND);
      busy     <= (state_n != IDLE);
      done     <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Bench for regfile_dump_tx: scoreboard of expected bytes, directed steps.
// Honors REG_DUMP_INDEX_EN when defined for the build.
module tb_regfile_dump_tx;

`ifdef REG_DUMP_INDEX_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int LAT_FULL = 32 * (NB + 1) + 1;
  localparam int LAT_ONE  = NB + 2;

  logic        clk;
  logic        clrn;
  logic        tx_ready;
  logic        start0, start1;
  logic [4:0]  rn0, rn1;
  logic [31:0] q0, q1;
  logic [7:0]  tx_data0, tx_data1;
  logic        tx_valid0, tx_valid1;
  logic        busy0, busy1;
  logic        done0, done1;

  logic [31:0] rf [32];
  logic [7:0]  sb0 [$];
  logic [7:0]  sb1 [$];
  logic        held_v;
  logic [7:0]  held_d;
  int          checks;
  int          errors;
  int          done0_cnt;
  int          done1_cnt;

  // Register-file model: combinational read, r0 reads zero
  assign q0 = (rn0 == 5'd0) ? 32'd0 : rf[rn0];
  assign q1 = (rn1 == 5'd0) ? 32'd0 : rf[rn1];

  regfile_dump_tx #(.FIRST_REG(0), .LAST_REG(31)) u_full (
    .clk(clk), .clrn(clrn), .start(start0), .rn(rn0), .q(q0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
    .busy(busy0), .done(done0)
  );

  regfile_dump_tx #(.FIRST_REG(5), .LAST_REG(5)) u_one (
    .clk(clk), .clrn(clrn), .start(start1), .rn(rn1), .q(q1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
    .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h required %h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input bit sel, input logic [7:0] b);
    if (sel) sb1.push_back(b);
    else     sb0.push_back(b);
  endtask

  task automatic push_dump(input bit sel, input int first, input int last);
    logic [31:0] w;
    for (int i = first; i <= last; i++) begin
      w = (i == 0) ? 32'd0 : rf[i];
`ifdef REG_DUMP_INDEX_EN
      push_byte(sel, 8'(i));
`endif
      push_byte(sel, w[31:24]);
      push_byte(sel, w[23:16]);
      push_byte(sel, w[15:8]);
      push_byte(sel, w[7:0]);
    end
  endtask

  // Per-cycle output check at the falling edge: scoreboard pop, hold stability, done count
  task automatic mon();
    logic [7:0] e;
    if (clrn !== 1'b1) begin
      held_v = 1'b0;
      return;
    end
    if (tx_valid0 && tx_ready) begin
      checks++;
      assert (sb0.size() > 0) else begin
        errors++;
        $error("FAIL extra_byte0 got %h required no byte", tx_data0);
      end
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        checks++;
        assert (tx_data0 === e) else begin
          errors++;
          $error("FAIL byte0 got %h required %h", tx_data0, e);
        end
      end
    end
    if (tx_valid1 && tx_ready) begin
      checks++;
      assert (sb1.size() > 0) else begin
        errors++;
        $error("FAIL extra_byte1 got %h required no byte", tx_data1);
      end
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        checks++;
        assert (tx_data1 === e) else begin
          errors++;
          $error("FAIL byte1 got %h required %h", tx_data1, e);
        end
      end
    end
    if (held_v) begin
      checks++;
      assert ({tx_valid0, tx_data0} === {1'b1, held_d}) else begin
        errors++;
        $error("FAIL hold got %b_%h required 1_%h", tx_valid0, tx_data0, held_d);
      end
    end
    held_v = tx_valid0 && !tx_ready;
    held_d = tx_data0;
    if (done0) done0_cnt++;
    if (done1) done1_cnt++;
  endtask

  task automatic step(input bit rdy);
    @(posedge clk);
    #1 tx_ready = rdy;
    @(negedge clk);
    mon();
  endtask

  // Called on the falling edge after the posedge that sampled start; k counts posedges since then
  task automatic wait_done(input bit sel, input bit bp, input bit pulse, input bit wr,
                           input int lat, input string tag);
    int k;
    k = 0;
    while (((sel ? done1 : done0) !== 1'b1) && k < 3000) begin
      if (pulse) start0 = (k % 7 == 3);
      if (wr && k == 2) rf[3] = 32'h1234_5678;
      step(bp ? ($urandom_range(0, 9) < 3) : 1'b1);
      k++;
    end
    if (pulse) start0 = 1'b0;
    if (lat > 0) chk({tag, "_lat"}, 32'(k), 32'(lat));
    else         chk({tag, "_timeout"}, 32'(k < 3000), 32'd1);
  endtask

  initial begin
    int d;
    logic [31:0] old3;
    checks = 0; errors = 0; done0_cnt = 0; done1_cnt = 0;
    held_v = 1'b0; held_d = 8'h00;
    clrn = 1'b0; tx_ready = 1'b1; start0 = 1'b0; start1 = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0101_0000 * 32'(i) + 32'(i);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(tx_valid0), 32'd0);
    chk("rst_busy",  32'(busy0),     32'd0);
    chk("rst_done",  32'(done0),     32'd0);
    chk("rst_rn",    32'(rn0),       32'd0);
    chk("rst_data",  32'(tx_data0),  32'd0);
    chk("rst_rn1",   32'(rn1),       32'd5);
    clrn = 1'b1;
    step(1'b1);
    step(1'b1);

    // full dump, tx_ready always high
    push_dump(1'b0, 0, 31);
    start0 = 1'b1;
    step(1'b1);
    start0 = 1'b0;
    chk("load_busy",  32'(busy0),     32'd1);
    chk("load_valid", 32'(tx_valid0), 32'd0);
    d = done0_cnt;
    wait_done(1'b0, 1'b0, 1'b0, 1'b0, LAT_FULL, "full");
    repeat (3) step(1'b1);
    chk("full_done_cnt", 32'(done0_cnt - d), 32'd1);
    chk("full_sb_empty", 32'(sb0.size()), 32'd0);
    chk("full_idle", 32'(busy0), 32'd0);

    // backpressure: ~30% ready, same byte stream
    push_dump(1'b0, 0, 31);
    start0 = 1'b1;
    step(1'b1);
    start0 = 1'b0;
    d = done0_cnt;
    wait_done(1'b0, 1'b1, 1'b0, 1'b0, 0, "bp");
    repeat (3) step(1'b1);
    chk("bp_done_cnt", 32'(done0_cnt - d), 32'd1);
    chk("bp_sb_empty", 32'(sb0.size()), 32'd0);

    // start pulses while busy, plus a write to r3 before rn reaches 3
    old3 = rf[3];
    rf[3] = 32'h1234_5678;
    push_dump(1'b0, 0, 31);
    rf[3] = old3;
    start0 = 1'b1;
    step(1'b1);
    start0 = 1'b0;
    d = done0_cnt;
    wait_done(1'b0, 1'b0, 1'b1, 1'b1, LAT_FULL, "pulse");
    repeat (3) step(1'b1);
    chk("pulse_done_cnt", 32'(done0_cnt - d), 32'd1);
    chk("pulse_sb_empty", 32'(sb0.size()), 32'd0);
    chk("pulse_idle", 32'(busy0), 32'd0);

    // start held high through DONE: second dump starts on the first IDLE cycle
    push_dump(1'b0, 0, 31);
    push_dump(1'b0, 0, 31);
    start0 = 1'b1;
    step(1'b1);
    d = done0_cnt;
    wait_done(1'b0, 1'b0, 1'b0, 1'b0, LAT_FULL, "hold1");
    chk("hold_gap_busy", 32'(busy0), 32'd0);
    step(1'b1);
    start0 = 1'b0;
    chk("hold_restart_busy", 32'(busy0), 32'd1);
    chk("hold_restart_rn",   32'(rn0),   32'd0);
    wait_done(1'b0, 1'b0, 1'b0, 1'b0, LAT_FULL, "hold2");
    repeat (3) step(1'b1);
    chk("hold_done_cnt", 32'(done0_cnt - d), 32'd2);
    chk("hold_sb_empty", 32'(sb0.size()), 32'd0);

    // asynchronous reset in the middle of a word
    push_dump(1'b0, 0, 31);
    start0 = 1'b1;
    step(1'b1);
    start0 = 1'b0;
    repeat (3) step(1'b1);
    chk("mid_valid", 32'(tx_valid0), 32'd1);
    clrn = 1'b0;
    #1;
    chk("mrst_valid", 32'(tx_valid0), 32'd0);
    chk("mrst_busy",  32'(busy0),     32'd0);
    chk("mrst_done",  32'(done0),     32'd0);
    chk("mrst_rn",    32'(rn0),       32'd0);
    chk("mrst_data",  32'(tx_data0),  32'd0);
    sb0.delete();
    held_v = 1'b0;
    step(1'b1);
    step(1'b1);
    clrn = 1'b1;
    d = done0_cnt;
    repeat (6) step(1'b1);
    chk("post_rst_valid", 32'(tx_valid0), 32'd0);
    chk("post_rst_busy",  32'(busy0),     32'd0);
    chk("post_rst_done",  32'(done0_cnt - d), 32'd0);

    // single-register range on the second instance
    rf[5] = 32'hDEAD_BEEF;
`ifdef REG_DUMP_INDEX_EN
    push_byte(1'b1, 8'h05);
`endif
    push_byte(1'b1, 8'hDE);
    push_byte(1'b1, 8'hAD);
    push_byte(1'b1, 8'hBE);
    push_byte(1'b1, 8'hEF);
    start1 = 1'b1;
    step(1'b1);
    start1 = 1'b0;
    chk("one_rn", 32'(rn1), 32'd5);
    d = done1_cnt;
    wait_done(1'b1, 1'b0, 1'b0, 1'b0, LAT_ONE, "one");
    repeat (3) step(1'b1);
    chk("one_done_cnt", 32'(done1_cnt - d), 32'd1);
    chk("one_sb_empty", 32'(sb1.size()), 32'd0);
    chk("one_idle_rn",  32'(rn1), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
